// File: rtl/pll_reset_sequencer.sv
// PLL reset/lock supervisor in the refclk domain: timed PLL reset, lock wait with retry,
// lock qualification and sys_rst release. Define PLL_SEQ_RETRY_LIMIT_EN for the FAULT state.
module pll_reset_sequencer #(
    parameter int RST_CYCLES    = 50,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1000,
    parameter int CNT_W         = 16,
    parameter int ERR_W         = 8,
    parameter int MAX_RETRIES   = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             locked_in,
    input  logic             restart,
    output logic             pll_rst,
    output logic             sys_rst,
    output logic             ready,
    output logic [ERR_W-1:0] retry_cnt,
    output logic [ERR_W-1:0] loss_cnt,
    output logic             fault
);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
    typedef enum logic [2:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAULT
    } state_e;

    localparam logic [ERR_W-1:0] RETRY_LIMIT = ERR_W'(MAX_RETRIES);
`else
    typedef enum logic [1:0] {
        S_RST_PLL,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN
    } state_e;

    logic unused_max_retries;
    assign unused_max_retries = ^MAX_RETRIES;
`endif

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);

    function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic               lock_meta_q, lock_s_q;
    logic [ERR_W-1:0]   retry_q, retry_d;
    logic [ERR_W-1:0]   loss_q, loss_d;
    logic               pll_rst_q, pll_rst_d;
    logic               sys_rst_q, sys_rst_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        loss_d  = loss_q;

        // restart wins over timeout and lock loss, so no counter moves on that cycle
        if (restart && state_q != S_RST_PLL) begin
            state_d = S_RST_PLL;
`ifdef PLL_SEQ_RETRY_LIMIT_EN
            if (state_q == S_FAULT) begin
                retry_d = '0;
            end
`endif
        end else begin
            unique case (state_q)
                S_RST_PLL: begin
                    if (timer_q == RST_LAST) begin
                        state_d = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (lock_s_q) begin
                        state_d = S_STABLE;
                    end else if (timer_q == TIMEOUT_LAST) begin
                        retry_d = sat_inc(retry_q);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                        state_d = (retry_d == RETRY_LIMIT) ? S_FAULT : S_RST_PLL;
`else
                        state_d = S_RST_PLL;
`endif
                    end
                end
                S_STABLE: begin
                    if (!lock_s_q) begin
                        state_d = S_WAIT_LOCK;
                    end else if (timer_q == STABLE_LAST) begin
                        state_d = S_RUN;
                        retry_d = '0;
                    end
                end
                S_RUN: begin
                    if (!lock_s_q) begin
                        state_d = S_RST_PLL;
                        loss_d  = sat_inc(loss_q);
                    end
                end
`ifdef PLL_SEQ_RETRY_LIMIT_EN
                S_FAULT: begin
                    state_d = S_FAULT;
                end
`endif
                default: begin
                    state_d = S_RST_PLL;
                end
            endcase
        end

        timer_d = (state_d != state_q) ? '0 : timer_q + 1'b1;

        // outputs are registered from the next state, so they track the current state glitch-free
        pll_rst_d = (state_d == S_RST_PLL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
`ifdef PLL_SEQ_RETRY_LIMIT_EN
        fault_d   = (state_d == S_FAULT);
`else
        fault_d   = 1'b0;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state_q     <= S_RST_PLL;
            timer_q     <= '0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            retry_q     <= '0;
            loss_q      <= '0;
            pll_rst_q   <= 1'b1;
            sys_rst_q   <= 1'b1;
            ready_q     <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            lock_meta_q <= locked_in;
            lock_s_q    <= lock_meta_q;
            retry_q     <= retry_d;
            loss_q      <= loss_d;
            pll_rst_q   <= pll_rst_d;
            sys_rst_q   <= sys_rst_d;
            ready_q     <= ready_d;
            fault_q     <= fault_d;
        end
    end

    assign pll_rst   = pll_rst_q;
    assign sys_rst   = sys_rst_q;
    assign ready     = ready_q;
    assign retry_cnt = retry_q;
    assign loss_cnt  = loss_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with short timing parameters; expected output
// snapshots are queued when stimulus is applied and compared after the DUT is clocked.
module tb_pll_reset_sequencer;

    localparam int ERR_W = 8;

    logic             refclk;
    logic             rst;
    logic             locked_in;
    logic             restart;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic [ERR_W-1:0] retry_cnt;
    logic [ERR_W-1:0] loss_cnt;
    logic             fault;

    int tests = 0;
    int fails = 0;

    typedef struct {
        string            tag;
        logic             pll;
        logic             sys;
        logic             rdy;
        logic [ERR_W-1:0] retry;
        logic [ERR_W-1:0] loss;
        logic             flt;
    } exp_t;

    exp_t sb[$];

    pll_reset_sequencer #(
        .RST_CYCLES   (4),
        .LOCK_TIMEOUT (20),
        .STABLE_CYCLES(8),
        .CNT_W        (16),
        .ERR_W        (ERR_W),
        .MAX_RETRIES  (2)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked_in(locked_in),
        .restart  (restart),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .retry_cnt(retry_cnt),
        .loss_cnt (loss_cnt),
        .fault    (fault)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, summary not reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge refclk);
            #1;
        end
    endtask

    task automatic check(input string tag, input string field,
                         input logic [ERR_W-1:0] obs, input logic [ERR_W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s.%s: observed %0h expected %0h", tag, field, obs, exp);
        end
    endtask

    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        check(e.tag, "pll_rst",   {7'b0, pll_rst},   {7'b0, e.pll});
        check(e.tag, "sys_rst",   {7'b0, sys_rst},   {7'b0, e.sys});
        check(e.tag, "ready",     {7'b0, ready},     {7'b0, e.rdy});
        check(e.tag, "retry_cnt", retry_cnt,         e.retry);
        check(e.tag, "loss_cnt",  loss_cnt,          e.loss);
        check(e.tag, "fault",     {7'b0, fault},     {7'b0, e.flt});
    endtask

    // queue the expected snapshot, advance n edges, then compare against the DUT
    task automatic sc(input string tag, input int n, input logic p, input logic s,
                      input logic r, input logic [ERR_W-1:0] rc,
                      input logic [ERR_W-1:0] lc, input logic f);
        exp_t e;
        e.tag = tag; e.pll = p; e.sys = s; e.rdy = r;
        e.retry = rc; e.loss = lc; e.flt = f;
        sb.push_back(e);
        tick(n);
        compare_head();
    endtask

    initial begin
        logic [ERR_W-1:0] r_after;

        rst       = 1'b1;
        locked_in = 1'b0;
        restart   = 1'b0;
        #1;
        sc("reset", 2, 1, 1, 0, 0, 0, 0);

        // pll_rst held for exactly four cycles after reset release
        rst = 1'b0;
        sc("t1_pulse1",    1, 1, 1, 0, 0, 0, 0);
        sc("t1_pulse3",    2, 1, 1, 0, 0, 0, 0);
        sc("t1_pulse_end", 1, 0, 1, 0, 0, 0, 0);

        // first lock timeout: 20 cycles in WAIT_LOCK, then a fresh pulse
        sc("t3_wait19",      19, 0, 1, 0, 0, 0, 0);
        sc("t3_timeout1",     1, 1, 1, 0, 1, 0, 0);
        sc("t3_repulse3",     3, 1, 1, 0, 1, 0, 0);
        sc("t3_repulse_end",  1, 0, 1, 0, 1, 0, 0);
        sc("t3_wait19b",     19, 0, 1, 0, 1, 0, 0);

`ifdef PLL_SEQ_RETRY_LIMIT_EN
        sc("t6_fault", 1, 0, 1, 0, 2, 0, 1);
        locked_in = 1'b1;
        sc("t6_fault_ignores_lock", 5, 0, 1, 0, 2, 0, 1);
        locked_in = 1'b0;
        sc("t6_fault_hold", 3, 0, 1, 0, 2, 0, 1);
        restart = 1'b1;
        sc("t6_restart",   1, 1, 1, 0, 0, 0, 0);
        restart = 1'b0;
        sc("t6_pulse3",    2, 1, 1, 0, 0, 0, 0);
        sc("t6_pulse4",    1, 1, 1, 0, 0, 0, 0);
        sc("t6_pulse_end", 1, 0, 1, 0, 0, 0, 0);
        r_after = 8'd0;
`else
        sc("t3_timeout2", 1, 1, 1, 0, 2, 0, 0);
        restart = 1'b1;
        sc("t3_restart_ignored", 1, 1, 1, 0, 2, 0, 0);
        restart = 1'b0;
        sc("t3_pulse_not_ext", 2, 1, 1, 0, 2, 0, 0);
        sc("t3_pulse_end2",    1, 0, 1, 0, 2, 0, 0);
        r_after = 8'd2;
`endif

        // lock glitch in STABLE at timer=5 forces a full requalification
        locked_in = 1'b1;
        sc("t4_stable_early", 6, 0, 1, 0, r_after, 0, 0);
        locked_in = 1'b0;
        sc("t4_glitch", 1, 0, 1, 0, r_after, 0, 0);
        locked_in = 1'b1;
        sc("t4_after_glitch",     2, 0, 1, 0, r_after, 0, 0);
        sc("t4_no_early_release", 8, 0, 1, 0, r_after, 0, 0);
        sc("t4_release",          1, 0, 0, 1, 0,       0, 0);

        // lock loss in RUN re-arms the sequence
        locked_in = 1'b0;
        sc("t5_ready_still", 2, 0, 0, 1, 0, 0, 0);
        sc("t5_loss",        1, 1, 1, 0, 0, 1, 0);
        sc("t5_pulse",       3, 1, 1, 0, 0, 1, 0);
        sc("t5_pulse_end",   1, 0, 1, 0, 0, 1, 0);

        // exact release latency: n+10 after locked_in is first sampled high
        locked_in = 1'b1;
        sc("t2_edge_n9",  10, 0, 1, 0, 0, 1, 0);
        sc("t2_edge_n10",  1, 0, 0, 1, 0, 1, 0);

        // restart coincident with lock loss: loss_cnt must not move
        locked_in = 1'b0;
        sc("t5b_pre", 2, 0, 0, 1, 0, 1, 0);
        restart = 1'b1;
        sc("t5b_restart_loss", 1, 1, 1, 0, 0, 1, 0);
        restart = 1'b0;
        sc("t5b_pulse",     3, 1, 1, 0, 0, 1, 0);
        sc("t5b_pulse_end", 1, 0, 1, 0, 0, 1, 0);

        // asynchronous reset mid-cycle clears everything including loss_cnt
        #2;
        rst = 1'b1;
        #1;
        sc("async_reset", 0, 1, 1, 0, 0, 0, 0);
        tick(2);
        rst = 1'b0;
        sc("post_reset_pulse", 1, 1, 1, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pll_reset_sequencer.md
Name: pll_reset_sequencer

Overview:
- Supervises the audio PLL (50 MHz refclk in, 12 MHz codec clock out) from the refclk domain.
- Drives the PLL reset with a timed pulse, waits for lock with a timeout and retry, and qualifies lock stability.
- Releases the downstream system reset only when lock is stable; on lock loss it re-arms the whole sequence.
- Sits between the board reset and the PLL, ahead of the codec/I2S logic.

Parameters:
- RST_CYCLES, 50: refclk cycles pll_rst is held high per attempt (>=1).
- LOCK_TIMEOUT, 50000: refclk cycles allowed in WAIT_LOCK before retry (>=1).
- STABLE_CYCLES, 1000: cycles lock must stay continuously high before release (>=1).
- CNT_W, 16: timer width; must hold max(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)-1.
- ERR_W, 8: width of retry_cnt and loss_cnt.
- MAX_RETRIES, 4: consecutive timeouts before FAULT; used only with the macro.

Ports:
- refclk  in  1  50 MHz reference clock, sole clock.
- rst  in  1  asynchronous, active-high reset.
- locked_in  in  1  PLL locked, asynchronous; 2-flop synchronised to lock_s internally.
- restart  in  1  single-cycle request to re-run the sequence.
- pll_rst  out  1  reset to the PLL, active-high.
- sys_rst  out  1  downstream reset, active-high.
- ready  out  1  high only in RUN.
- retry_cnt  out  ERR_W  consecutive lock timeouts, saturating.
- loss_cnt  out  ERR_W  lock losses while in RUN, saturating.
- fault  out  1  retry limit reached; tied 0 without the macro.

Behaviour:
- Reset (async): state=RST_PLL, timer=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0, retry_cnt=0, loss_cnt=0, fault=0.
- All outputs are flops loaded from next-state decode, so each equals the Moore decode of the current state with no combinational path:
  - pll_rst = (state==RST_PLL)
  - sys_rst = (state!=RUN)
  - ready = (state==RUN)
- Timer: clears on every state change; otherwise increments.
- RST_PLL: go to WAIT_LOCK when timer==RST_CYCLES-1, so pll_rst is high for exactly RST_CYCLES cycles.
- WAIT_LOCK:
  - lock_s=1 -> STABLE.
  - Otherwise, timer==LOCK_TIMEOUT-1 -> RST_PLL, retry_cnt+1 (saturates at all-ones).
- STABLE:
  - lock_s=0 -> WAIT_LOCK; timer restarts, no count change.
  - lock_s=1 and timer==STABLE_CYCLES-1 -> RUN; retry_cnt cleared.
- RUN: lock_s=0 -> RST_PLL, loss_cnt+1 (saturating).
- restart=1 in any state other than RST_PLL -> RST_PLL with timer cleared.
  - restart has priority over lock-loss and timeout on the same cycle; neither counter increments.
  - restart during RST_PLL is ignored; the pulse is not extended.
- Latency: locked_in sampled high at edge n gives lock_s=1 after edge n+1, STABLE entered at edge n+2, sys_rst falls after edge n+2+STABLE_CYCLES.
- Reset mid-operation returns immediately to the reset values; counters clear.
- loss_cnt clears only on rst.

Optional Feature:
- Macro PLL_SEQ_RETRY_LIMIT_EN.
- Defined:
  - The timeout that makes retry_cnt reach MAX_RETRIES enters FAULT instead of RST_PLL.
  - FAULT: pll_rst=0, sys_rst=1, ready=0, fault=1; locked_in is ignored.
  - Exit only via restart (-> RST_PLL, retry_cnt cleared, fault=0) or rst.
- Undefined: no FAULT state, fault tied 0, retries are unlimited.

Test Plan (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8):
1. Release rst, locked_in=0 -> pll_rst high exactly 4 cycles then low; sys_rst=1, ready=0.
2. locked_in rises, sampled at edge n during WAIT_LOCK -> sys_rst=0 and ready=1 after edge n+10; retry_cnt=0.
3. locked_in held 0 -> after 20 WAIT_LOCK cycles pll_rst pulses 4 cycles, retry_cnt=1; after a second timeout, retry_cnt=2.
4. locked_in drops 1 cycle in STABLE at timer=5 -> returns to WAIT_LOCK, full 8 stable cycles required again; sys_rst never drops early.
5. In RUN, locked_in falls -> sys_rst=1 and ready=0 within 3 cycles, loss_cnt=1, 4-cycle pll_rst pulse. restart plus lock loss on the same cycle -> loss_cnt unchanged.
6. Macro defined, MAX_RETRIES=2, locked_in=0 -> fault=1 after the 2nd timeout with pll_rst=0; restart pulse -> fault=0, retry_cnt=0, 4-cycle pll_rst pulse.
